// File: rtl/serial_word_rx_pkg.sv
// rtl/serial_word_rx_pkg.sv - shared types and constants for the serial word receiver
//
// Purpose: state encoding and default word width used by serial_word_rx and
//          its output holding register.
// Contents:
//   rx_state_e : IDLE (waiting for a Start-qualified bit) / SHIFT (frame in progress)
//   WORD_W     : default word width, matching the upstream shift register
package serial_word_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    localparam int WORD_W = 4;

endpackage

// File: rtl/serial_word_rx_word_out_buf.sv
// rtl/serial_word_rx_word_out_buf.sv - output holding register with valid/ready and overrun
//
// Purpose: holds one completed word until downstream accepts it. A word
//          arriving while the held word is still unaccepted is dropped and
//          flagged in a sticky overrun bit.
// Ports:
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   load_i     : one-cycle pulse, word_i is a completed word
//   word_i     : completed word
//   ready_i    : downstream accepts data_o this cycle
//   data_o     : held word (stable while valid_o=1 and ready_i=0)
//   valid_o    : data_o holds an unaccepted word
//   overrun_o  : sticky, a completed word was dropped
module serial_word_rx_word_out_buf
    import serial_word_rx_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [N-1:0] word_i,
    input  logic         ready_i,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         overrun_o
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_i) begin
            // The slot is free if empty or being drained this same cycle.
            if (!valid_q || ready_i) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - LSB-first serial-to-parallel word receiver
//
// Purpose: collects N strobed serial bits, the first qualified by Start, into
//          a word and hands it to a double-buffered valid/ready output.
// Ports:
//   Clk      : system clock
//   Reset    : synchronous active-high reset
//   SerIn    : serial data bit
//   SerValid : SerIn is valid this cycle
//   Start    : first bit of a frame (only meaningful with SerValid=1)
//   Ready    : downstream accepts Data this cycle
//   Data     : assembled word, registered
//   Valid    : Data holds an unaccepted word
//   Busy     : a frame is in progress
//   Overrun  : sticky, a completed word was dropped
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         SerIn,
    input  logic         SerValid,
    input  logic         Start,
    input  logic         Ready,
    output logic [N-1:0] Data,
    output logic         Valid,
    output logic         Busy,
    output logic         Overrun
);

    localparam int CW = $clog2(N + 1);

    rx_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  shifted;
    logic          load;

    // New bits enter at the top so the first bit ends up in bit 0.
    assign shifted = {SerIn, sh_q[N-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        load    = 1'b0;
        if (SerValid) begin
            if (Start) begin
                // Start always (re)opens a frame; any partial word is discarded.
                state_d = SHIFT;
                cnt_d   = CW'(1);
                sh_d    = {SerIn, {(N-1){1'b0}}};
            end else if (state_q == SHIFT) begin
                sh_d = shifted;
                if (cnt_q == CW'(N - 1)) begin
                    // Nth bit: the shifted value is the finished word.
                    load    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    assign Busy = (state_q == SHIFT);

    serial_word_rx_word_out_buf #(
        .N (N)
    ) u_word_out_buf (
        .clk_i     (Clk),
        .reset_i   (Reset),
        .load_i    (load),
        .word_i    (shifted),
        .ready_i   (Ready),
        .data_o    (Data),
        .valid_o   (Valid),
        .overrun_o (Overrun)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - self-checking bench for serial_word_rx
module tb_serial_word_rx;

    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         SerIn = 1'b0;
    logic         SerValid = 1'b0;
    logic         Start = 1'b0;
    logic         Ready = 1'b0;
    logic [N-1:0] Data;
    logic         Valid;
    logic         Busy;
    logic         Overrun;

    int total = 0;
    int bad = 0;
    logic [N-1:0] exp_q[$];

    serial_word_rx #(.N(N)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .SerIn    (SerIn),
        .SerValid (SerValid),
        .Start    (Start),
        .Ready    (Ready),
        .Data     (Data),
        .Valid    (Valid),
        .Busy     (Busy),
        .Overrun  (Overrun)
    );

    always #5 Clk = ~Clk;

    // Scoreboard: every transfer the DUT offers is checked against the oldest expected word.
    always @(negedge Clk) begin
        if (Valid === 1'b1 && Ready === 1'b1 && Reset === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got Data=%h, none expected", Data);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (Data !== e) begin
                    bad++;
                    $display("FAIL xfer_data: got %h want %h", Data, e);
                end
            end
        end
    end

    // Drive one cycle of inputs, pass the rising edge, return 1 time unit later.
    task automatic step(input logic rst, input logic sv, input logic st,
                        input logic b, input logic rdy);
        Reset    = rst;
        SerValid = sv;
        Start    = st;
        SerIn    = b;
        Ready    = rdy;
        @(posedge Clk);
        #1;
    endtask

    // Send one frame LSB-first; optional idle gap after each non-final bit.
    task automatic send_frame(input logic [N-1:0] w, input logic gap, input logic rdy_last);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, (i == 0), w[i], (i == N - 1) ? rdy_last : 1'b0);
            if (gap && i < N - 1) step(1'b0, 1'b0, 1'b0, ~w[i], 1'b0);
        end
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({Data, Valid, Busy, Overrun} !== {4'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset_state: got D=%h V=%b B=%b O=%b want 0", Data, Valid, Busy, Overrun);
        end
    endtask

    task automatic test_basic;
        logic [N-1:0] w;
        w = 4'hD;
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, (i == 0), w[i], 1'b0);
            if (i < N - 1) begin
                total++;
                if (Busy !== 1'b1 || Valid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_busy[%0d]: got B=%b V=%b want B=1 V=0", i, Busy, Valid);
                end
            end
        end
        exp_q.push_back(w);
        total++;
        if (Valid !== 1'b1 || Data !== 4'hD || Busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: got V=%b D=%h B=%b want V=1 D=d B=0", Valid, Data, Busy);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (Valid !== 1'b0 || Data !== 4'hD) begin
            bad++;
            $display("FAIL basic_accept: got V=%b D=%h want V=0 D=d", Valid, Data);
        end
    endtask

    task automatic test_gapped;
        logic [N-1:0] w;
        w = 4'hD;
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, (i == 0), w[i], 1'b0);
            if (i < N - 1) begin
                step(1'b0, 1'b0, 1'b0, ~w[i], 1'b0);
                total++;
                if (Valid !== 1'b0 || Busy !== 1'b1) begin
                    bad++;
                    $display("FAIL gap_hold[%0d]: got V=%b B=%b want V=0 B=1", i, Valid, Busy);
                end
            end
        end
        exp_q.push_back(w);
        total++;
        if (Valid !== 1'b1 || Data !== 4'hD) begin
            bad++;
            $display("FAIL gap_done: got V=%b D=%h want V=1 D=d", Valid, Data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        send_frame(4'hD, 1'b0, 1'b0);
        exp_q.push_back(4'hD);
        total++;
        if (Valid !== 1'b1 || Data !== 4'hD || Overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got V=%b D=%h O=%b want V=1 D=d O=0", Valid, Data, Overrun);
        end
        send_frame(4'h6, 1'b0, 1'b0);
        total++;
        if (Valid !== 1'b1 || Data !== 4'hD || Overrun !== 1'b1) begin
            bad++;
            $display("FAIL b2b_overrun: got V=%b D=%h O=%b want V=1 D=d O=1", Valid, Data, Overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (Valid !== 1'b0 || Overrun !== 1'b1) begin
            bad++;
            $display("FAIL b2b_sticky: got V=%b O=%b want V=0 O=1", Valid, Overrun);
        end
    endtask

    task automatic test_same_cycle;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'hD, 1'b0, 1'b0);
        exp_q.push_back(4'hD);
        send_frame(4'h6, 1'b0, 1'b1);
        exp_q.push_back(4'h6);
        total++;
        if (Valid !== 1'b1 || Data !== 4'h6 || Overrun !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle: got V=%b D=%h O=%b want V=1 D=6 O=0", Valid, Data, Overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'hF, 1'b0, 1'b0);
        exp_q.push_back(4'hF);
        total++;
        if (Valid !== 1'b1 || Data !== 4'hF || Overrun !== 1'b0) begin
            bad++;
            $display("FAIL abort: got V=%b D=%h O=%b want V=1 D=f O=0", Valid, Data, Overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        send_frame(4'hD, 1'b0, 1'b0);   // left pending, lost by the reset below
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if ({Data, Valid, Busy, Overrun} !== {4'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset_mid: got D=%h V=%b B=%b O=%b want 0", Data, Valid, Busy, Overrun);
        end
        send_frame(4'h9, 1'b0, 1'b0);
        exp_q.push_back(4'h9);
        total++;
        if (Valid !== 1'b1 || Data !== 4'h9) begin
            bad++;
            $display("FAIL reset_mid_frame: got V=%b D=%h want V=1 D=9", Valid, Data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gapped;
        test_back_to_back;
        test_same_cycle;
        test_abort;
        test_reset_mid;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d words left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Deserializer that sits directly downstream of the n-bit shift register's serial output.
- Collects N serial bits, LSB-first, into a parallel word under a bit-strobe qualifier.
- Presents each completed word on a registered valid/ready output port for a downstream n-bit register or counter stage.
- Double-buffered: a new word can be received while the previous one waits for acceptance.

Parameters:
- N, 4, word width in bits (N >= 2); matches the shift register's default width.
- CW, $clog2(N+1), bit-counter width; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- SerIn  input  1  serial data bit.
- SerValid  input  1  SerIn is valid this cycle (bit strobe).
- Start  input  1  qualifies the first bit of a frame; meaningful only when SerValid=1.
- Ready  input  1  downstream accepts Data this cycle.
- Data  output  N  assembled word, registered.
- Valid  output  1  Data holds an unaccepted word.
- Busy  output  1  a frame is in progress (state SHIFT).
- Overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (sampled on Clk edge while Reset=1), takes priority over everything:
  - state=IDLE, bit count=0, shift buffer=0.
  - Data=0, Valid=0, Busy=0, Overrun=0.
- Bit capture: on an accepted bit, the shift buffer shifts right and SerIn enters bit N-1. After N bits, the first-received bit sits in bit 0 (LSB-first).
- IDLE:
  - SerValid=1 & Start=1: capture bit as bit 0, count=1, go to SHIFT.
  - SerValid=1 & Start=0: bit ignored.
- SHIFT:
  - SerValid=0: hold all state.
  - SerValid=1 & Start=0: capture, count+1.
  - SerValid=1 & Start=1: abort the current frame and restart. Captured bit becomes bit 0, count=1, partial word discarded, Overrun unaffected.
  - Frame completes when the Nth bit is captured: go to IDLE, count=0.
- Completion is registered: the completed word appears on Data, with Valid=1, on the cycle after the Nth bit's Clk edge (1-cycle latency from last bit to Valid).
- Output handshake: a transfer occurs on any cycle with Valid=1 & Ready=1.
  - Transfer with no completion that cycle: Valid falls next cycle; Data holds its old value.
  - Completion while Valid=0: load Data, set Valid.
  - Completion while Valid=1 & Ready=1 (same cycle): load new Data, Valid stays 1, no overrun.
  - Completion while Valid=1 & Ready=0: new word dropped, Data unchanged, Overrun set (sticky until Reset).
- Data is stable while Valid=1 & Ready=0.
- Busy = (state==SHIFT); combinational from the state register.
- Back-to-back frames: the next frame's Start bit may arrive the cycle immediately after the Nth bit. Full throughput is one bit per cycle, no gaps.
- Reset mid-frame: partial word discarded; a pending Valid word is lost.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, SHIFT=1'b1.
  - default width constant WORD_W=4.
- One natural sub-module: word_out_buf, the output holding register with the Valid/Ready/Overrun logic. Inputs: load pulse, word. Outputs: Data, Valid, Overrun.
- The shift buffer and bit counter stay in the top module.

Test Plan:
- N=4, Start+bit on cycle 0, then bits 1,0,1,1 with SerValid=1 every cycle -> Busy=1 for cycles 1-3; Data=4'hD, Valid=1 on cycle 4; Ready=1 on cycle 4 -> Valid=0 on cycle 5.
- Same frame with SerValid toggling 1,0,1,0,... -> identical Data=4'hD, Valid asserts one cycle after the 4th strobed bit; no bits lost.
- Two back-to-back frames 4'hD then 4'h6 (bits 0,1,1,0), Ready held 0 -> first word held at Data=4'hD, Overrun=1 after second completion; Ready=1 -> transfer 4'hD, Valid=0, Overrun stays 1.
- Frame 4'h6 completes on the same cycle that Ready=1 accepts pending 4'hD -> Data=4'h6, Valid stays 1, Overrun=0.
- Start re-asserted after 2 bits of a frame, then bits 1,1,1,1 -> Data=4'hF; aborted partial bits absent.
- Reset=1 for one cycle mid-frame with Valid=1 -> next cycle Data=0, Valid=0, Busy=0, Overrun=0; a fresh frame 4'h9 then completes normally.
